// File: rtl/piece_dropper_if.sv
// -----------------------------------------------------------------------------
// piece_dropper_if
// Bundles the drop request handshake and the win-checker exchange of the
// Connect-4 piece dropper.
//   drop_valid / drop_col   : column drop request from the controller
//   drop_ready              : request accepted when high together with valid
//   drop_done / drop_err    : one-cycle completion / rejection pulses
//   placed_row              : row of the most recently placed piece
//   check_en                : one-cycle strobe to the win checker
//   win_flag / winner_id    : checker result, valid the cycle after check_en
// master = controller/checker side, slave = piece dropper.
// -----------------------------------------------------------------------------
interface piece_dropper_if;
  logic       drop_valid;
  logic [2:0] drop_col;
  logic       drop_ready;
  logic       drop_done;
  logic       drop_err;
  logic [2:0] placed_row;
  logic       check_en;
  logic       win_flag;
  logic [1:0] winner_id;

  modport master (
    output drop_valid, drop_col, win_flag, winner_id,
    input  drop_ready, drop_done, drop_err, placed_row, check_en
  );

  modport slave (
    input  drop_valid, drop_col, win_flag, winner_id,
    output drop_ready, drop_done, drop_err, placed_row, check_en
  );
endinterface

// File: rtl/piece_dropper.sv
// -----------------------------------------------------------------------------
// piece_dropper
// Owns the Connect-4 board. A column drop is resolved by scanning the column
// bottom-up one cell per cycle; the first empty cell receives the current
// player's piece, the win checker is strobed the following cycle and its
// result is latched the cycle after that.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   clear             : synchronous new-game, same effect as rst
//   bus (slave)       : drop handshake and win-checker exchange
//   board             : cell values, 00 empty, 01/10 player pieces
//   current_player    : player whose move is next
//   game_over, winner : sticky end-of-game status and winning id
//   draw              : sticky, board filled without a win
//   move_count        : number of pieces placed
// -----------------------------------------------------------------------------
module piece_dropper #(
  parameter int         ROWS         = 6,
  parameter int         COLS         = 7,
  parameter logic [1:0] FIRST_PLAYER = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  piece_dropper_if.slave   bus,
  output logic [1:0]       board [0:ROWS-1][0:COLS-1],
  output logic [1:0]       current_player,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic             draw,
  output logic [5:0]       move_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    WRITE = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [2:0] LAST_ROW = 3'(ROWS - 1);
  localparam logic [3:0] COLS_W   = 4'(COLS);
  localparam logic [5:0] CELLS    = 6'(ROWS * COLS);

  state_t     state_r, state_next;
  logic [2:0] ptr_r, ptr_next;
  logic [2:0] col_r, col_next;
  logic       over_next;

  logic [1:0] board_r [0:ROWS-1][0:COLS-1];
  logic [1:0] player_r;
  logic [5:0] count_r;
  logic       over_r;
  logic       draw_r;
  logic [1:0] winner_r;
  logic [2:0] row_r;
  logic       ready_r;
  logic       done_r;
  logic       err_r;
  logic       chk_r;

  // Only the two legal player ids ever alternate.
  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == 2'b01) ? 2'b10 : 2'b01;
  endfunction

  // Next-state logic: handshake, bottom-up column scan and end-of-game update.
  always_comb begin
    state_next = state_r;
    ptr_next   = ptr_r;
    col_next   = col_r;
    over_next  = over_r;
    case (state_r)
      IDLE: begin
        if (bus.drop_valid && ready_r) begin
          col_next = bus.drop_col;
          ptr_next = LAST_ROW;
          if ({1'b0, bus.drop_col} >= COLS_W) begin
            state_next = ERR;
          end else begin
            state_next = SCAN;
          end
        end else begin
          state_next = IDLE;
        end
      end
      SCAN: begin
        if (board_r[ptr_r][col_r] == 2'b00) begin
          state_next = WRITE;
        end else if (ptr_r == 3'd0) begin
          state_next = ERR;
        end else begin
          ptr_next = ptr_r - 3'd1;
        end
      end
      WRITE: state_next = CHECK;
      CHECK: state_next = DONE;
      DONE: begin
        state_next = IDLE;
        if (bus.win_flag) begin
          over_next = 1'b1;
        end else if (count_r == CELLS) begin
          over_next = 1'b1;
        end else begin
          over_next = over_r;
        end
      end
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, control registers and pulse outputs; the pulses are registered
  // decodes of the state being entered so they line up with that state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      ptr_r    <= 3'd0;
      col_r    <= 3'd0;
      player_r <= FIRST_PLAYER;
      count_r  <= 6'd0;
      over_r   <= 1'b0;
      draw_r   <= 1'b0;
      winner_r <= 2'b00;
      row_r    <= 3'd0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      chk_r    <= 1'b0;
    end else if (clear) begin
      state_r  <= IDLE;
      ptr_r    <= 3'd0;
      col_r    <= 3'd0;
      player_r <= FIRST_PLAYER;
      count_r  <= 6'd0;
      over_r   <= 1'b0;
      draw_r   <= 1'b0;
      winner_r <= 2'b00;
      row_r    <= 3'd0;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
      chk_r    <= 1'b0;
    end else begin
      state_r <= state_next;
      ptr_r   <= ptr_next;
      col_r   <= col_next;
      over_r  <= over_next;
      ready_r <= (state_next == IDLE) && !over_next;
      done_r  <= (state_next == DONE);
      err_r   <= (state_next == ERR);
      chk_r   <= (state_next == CHECK);
      case (state_r)
        WRITE: begin
          row_r    <= ptr_r;
          count_r  <= count_r + 6'd1;
          player_r <= other_player(player_r);
        end
        DONE: begin
          if (bus.win_flag) begin
            winner_r <= bus.winner_id;
          end else if (count_r == CELLS) begin
            draw_r   <= 1'b1;
            winner_r <= 2'b00;
          end else begin
            winner_r <= winner_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Board storage: cleared on rst/clear, one cell written in WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          board_r[r][c] <= 2'b00;
        end
      end
    end else if (clear) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          board_r[r][c] <= 2'b00;
        end
      end
    end else if (state_r == WRITE) begin
      board_r[ptr_r][col_r] <= player_r;
    end else begin
      board_r[0][0] <= board_r[0][0];
    end
  end

  assign board          = board_r;
  assign current_player = player_r;
  assign game_over      = over_r;
  assign winner         = winner_r;
  assign draw           = draw_r;
  assign move_count     = count_r;

  assign bus.drop_ready = ready_r;
  assign bus.drop_done  = done_r;
  assign bus.drop_err   = err_r;
  assign bus.check_en   = chk_r;
  assign bus.placed_row = row_r;

endmodule

// File: tb/tb_piece_dropper.sv
module tb_piece_dropper;

  typedef logic [1:0] board_t [0:5][0:6];

  logic clk = 1'b0;
  logic rst;
  logic clear;
  always #5 clk = ~clk;

  piece_dropper_if bus ();

  board_t     board;
  logic [1:0] current_player;
  logic       game_over;
  logic [1:0] winner;
  logic       draw;
  logic [5:0] move_count;

  piece_dropper #(.ROWS(6), .COLS(7), .FIRST_PLAYER(2'b01)) dut (
    .clk(clk), .rst(rst), .clear(clear), .bus(bus),
    .board(board), .current_player(current_player), .game_over(game_over),
    .winner(winner), .draw(draw), .move_count(move_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: column heights plus a board image.
  board_t     mboard;
  int         height [7];
  logic [1:0] mplayer;
  int         mcount;
  bit         mover;
  bit         mdraw;
  logic [1:0] mwinner;
  int         mrow;

  // Observations from one drop attempt (cycle index after the handshake edge).
  int     chk_cyc, done_cyc, err_cyc, chk_cnt, done_cnt, err_cnt, both_cnt;
  board_t snap;

  task automatic model_reset();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) mboard[r][c] = 2'b00;
    for (int c = 0; c < 7; c++) height[c] = 0;
    mplayer = 2'b01; mcount = 0; mover = 0; mdraw = 0; mwinner = 2'b00; mrow = 0;
  endtask

  // kind: 0 ignored, 1 rejected, 2 placed; k = pieces already in the column.
  task automatic model_drop(input int col, input bit win, input logic [1:0] wid,
                            output int kind, output int k);
    k = (col < 7) ? height[col] : 0;
    if (mover) kind = 0;
    else if (col >= 7 || height[col] == 6) kind = 1;
    else begin
      kind = 2;
      mrow = 5 - height[col];
      mboard[mrow][col] = mplayer;
      height[col]++;
      mcount++;
      mplayer = (mplayer == 2'b01) ? 2'b10 : 2'b01;
      if (win) begin mover = 1; mwinner = wid; end
      else if (mcount == 42) begin mover = 1; mdraw = 1; mwinner = 2'b00; end
    end
  endtask

  function automatic bit same_board(input board_t a, input board_t b);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (a[r][c] !== b[r][c]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0;
    bus.drop_valid = 1'b0; bus.drop_col = 3'd0;
    bus.win_flag = 1'b0; bus.winner_id = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic do_clear();
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_reset();
  endtask

  task automatic handshake(input int col);
    @(negedge clk);
    bus.drop_valid = 1'b1;
    bus.drop_col = 3'(col);
    @(posedge clk);
    #1 bus.drop_valid = 1'b0;
  endtask

  // One drop attempt, observed for a bounded number of cycles; drives the
  // checker result in the cycle after check_en when win is requested.
  task automatic do_drop(input int col, input bit win, input logic [1:0] wid);
    chk_cyc = -1; done_cyc = -1; err_cyc = -1;
    chk_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
    handshake(col);
    for (int n = 1; n <= 20 && done_cyc < 0 && err_cyc < 0; n++) begin
      @(negedge clk);
      if (bus.drop_done && bus.drop_err) both_cnt++;
      if (bus.drop_done) begin done_cnt++; done_cyc = n; end
      if (bus.drop_err) begin err_cnt++; err_cyc = n; end
      if (bus.check_en) begin
        chk_cnt++; chk_cyc = n; snap = board;
        @(posedge clk);
        #1 bus.win_flag = win; bus.winner_id = wid;
      end
    end
    @(posedge clk);
    #1 bus.win_flag = 1'b0; bus.winner_id = 2'b00;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (!same_board(board, mboard)) $display("FAIL reset_board not empty"); else n_pass++;
    n_checks++; if (current_player !== 2'b01) $display("FAIL reset_player got %b want 01", current_player); else n_pass++;
    n_checks++; if (move_count !== 6'd0) $display("FAIL reset_count got %0d want 0", move_count); else n_pass++;
    n_checks++; if ({game_over, draw, winner} !== 4'b0000) $display("FAIL reset_status got %b want 0000", {game_over, draw, winner}); else n_pass++;
    n_checks++; if ({bus.drop_ready, bus.drop_done, bus.drop_err, bus.check_en, bus.placed_row} !== 7'b1000000)
      $display("FAIL reset_handshake got %b want 1000000", {bus.drop_ready, bus.drop_done, bus.drop_err, bus.check_en, bus.placed_row}); else n_pass++;
  endtask

  task automatic test_single_drop();
    int kind, k;
    do_reset();
    model_drop(3, 1'b0, 2'b00, kind, k);
    do_drop(3, 1'b0, 2'b00);
    n_checks++; if (chk_cyc !== 3) $display("FAIL single_check_en cycle got %0d want 3", chk_cyc); else n_pass++;
    n_checks++; if (done_cyc !== 4) $display("FAIL single_done cycle got %0d want 4", done_cyc); else n_pass++;
    n_checks++; if (snap[5][3] !== 2'b01) $display("FAIL single_board_at_check got %b want 01", snap[5][3]); else n_pass++;
    n_checks++; if (bus.placed_row !== 3'd5) $display("FAIL single_row got %0d want 5", bus.placed_row); else n_pass++;
    n_checks++; if (current_player !== 2'b10) $display("FAIL single_player got %b want 10", current_player); else n_pass++;
    n_checks++; if (move_count !== 6'd1) $display("FAIL single_count got %0d want 1", move_count); else n_pass++;
    n_checks++; if (!same_board(board, mboard)) $display("FAIL single_board differs from model"); else n_pass++;
  endtask

  task automatic test_full_column();
    int kind, k, bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      model_drop(0, 1'b0, 2'b00, kind, k);
      do_drop(0, 1'b0, 2'b00);
      if (done_cyc != 4 + k || chk_cyc != 3 + k || err_cnt != 0) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL fill_col0 latency errors got %0d want 0", bad); else n_pass++;
    model_drop(0, 1'b0, 2'b00, kind, k);
    do_drop(0, 1'b0, 2'b00);
    n_checks++; if (err_cyc !== 7) $display("FAIL full_err cycle got %0d want 7", err_cyc); else n_pass++;
    n_checks++; if ({done_cnt, chk_cnt} !== {32'd0, 32'd0}) $display("FAIL full_no_done got %0d/%0d want 0/0", done_cnt, chk_cnt); else n_pass++;
    n_checks++; if (move_count !== 6'd6) $display("FAIL full_count got %0d want 6", move_count); else n_pass++;
    n_checks++; if (current_player !== mplayer) $display("FAIL full_player got %b want %b", current_player, mplayer); else n_pass++;
    n_checks++; if (!same_board(board, mboard)) $display("FAIL full_board differs from model"); else n_pass++;
  endtask

  task automatic test_bad_column();
    int kind, k;
    model_drop(7, 1'b0, 2'b00, kind, k);
    do_drop(7, 1'b0, 2'b00);
    n_checks++; if (err_cyc !== 1) $display("FAIL badcol_err cycle got %0d want 1", err_cyc); else n_pass++;
    n_checks++; if ({chk_cnt, done_cnt} !== {32'd0, 32'd0}) $display("FAIL badcol_no_check got %0d/%0d want 0/0", chk_cnt, done_cnt); else n_pass++;
    n_checks++; if (move_count !== 6'd6 || !same_board(board, mboard)) $display("FAIL badcol_state count %0d want 6 or board changed", move_count); else n_pass++;
  endtask

  task automatic test_win();
    int kind, k;
    do_reset();
    model_drop(2, 1'b0, 2'b00, kind, k); do_drop(2, 1'b0, 2'b00);
    model_drop(4, 1'b1, 2'b01, kind, k); do_drop(4, 1'b1, 2'b01);
    n_checks++; if ({game_over, winner, draw} !== 4'b1010) $display("FAIL win_status got %b want 1010", {game_over, winner, draw}); else n_pass++;
    n_checks++; if (bus.drop_ready !== 1'b0) $display("FAIL win_ready got %b want 0", bus.drop_ready); else n_pass++;
    model_drop(5, 1'b0, 2'b00, kind, k); do_drop(5, 1'b0, 2'b00);
    n_checks++; if ({done_cnt, err_cnt, chk_cnt} !== {32'd0, 32'd0, 32'd0}) $display("FAIL win_ignored got %0d/%0d/%0d want 0/0/0", done_cnt, err_cnt, chk_cnt); else n_pass++;
    n_checks++; if (!same_board(board, mboard) || move_count !== 6'd2) $display("FAIL win_board changed count %0d want 2", move_count); else n_pass++;
  endtask

  task automatic test_draw();
    int kind, k, bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        model_drop(c, 1'b0, 2'b00, kind, k);
        do_drop(c, 1'b0, 2'b00);
        if (done_cyc != 4 + k || both_cnt != 0) bad++;
      end
    n_checks++; if (bad !== 0) $display("FAIL draw_fill errors got %0d want 0", bad); else n_pass++;
    n_checks++; if ({draw, game_over, winner} !== 4'b1100) $display("FAIL draw_status got %b want 1100", {draw, game_over, winner}); else n_pass++;
    n_checks++; if (move_count !== 6'd42) $display("FAIL draw_count got %0d want 42", move_count); else n_pass++;
    n_checks++; if (!same_board(board, mboard)) $display("FAIL draw_board differs from model"); else n_pass++;
  endtask

  task automatic test_random();
    int kind, k, col, exp_done, exp_err, exp_chk;
    bit win;
    logic [1:0] wid;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (mover && $urandom_range(0, 1) == 1) do_clear();
      col = $urandom_range(0, 7);
      win = ($urandom_range(0, 15) == 0);
      wid = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
      model_drop(col, win, wid, kind, k);
      do_drop(col, win, wid);
      exp_done = (kind == 2) ? 4 + k : -1;
      exp_chk  = (kind == 2) ? 3 + k : -1;
      exp_err  = (kind == 1) ? ((col >= 7) ? 1 : 7) : -1;
      n_checks++;
      if (done_cyc != exp_done || chk_cyc != exp_chk || err_cyc != exp_err || both_cnt != 0)
        $display("FAIL rand_timing col %0d got d%0d c%0d e%0d want d%0d c%0d e%0d", col, done_cyc, chk_cyc, err_cyc, exp_done, exp_chk, exp_err);
      else n_pass++;
      n_checks++;
      if (!same_board(board, mboard) || move_count !== 6'(mcount) || current_player !== mplayer || bus.placed_row !== 3'(mrow))
        $display("FAIL rand_state count %0d/%0d player %b/%b row %0d/%0d (got/want)", move_count, mcount, current_player, mplayer, bus.placed_row, mrow);
      else n_pass++;
      n_checks++;
      if ({game_over, draw, winner} !== {mover, mdraw, mwinner})
        $display("FAIL rand_status got %b want %b", {game_over, draw, winner}, {mover, mdraw, mwinner});
      else n_pass++;
    end
  endtask

  task automatic test_abort_rst();
    int kind, k, pulses;
    do_reset();
    model_drop(1, 1'b0, 2'b00, kind, k); do_drop(1, 1'b0, 2'b00);
    handshake(1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if (!same_board(board, mboard) || move_count !== 6'd0) $display("FAIL rst_abort_board count %0d want 0 or board not empty", move_count); else n_pass++;
    n_checks++; if ({current_player, bus.placed_row, bus.drop_done, bus.drop_err, bus.check_en} !== 8'b01000000)
      $display("FAIL rst_abort_outputs got %b want 01000000", {current_player, bus.placed_row, bus.drop_done, bus.drop_err, bus.check_en}); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.drop_done || bus.drop_err || bus.check_en) pulses++;
    end
    n_checks++; if (pulses !== 0 || bus.drop_ready !== 1'b1) $display("FAIL rst_abort_quiet pulses %0d want 0, ready %b want 1", pulses, bus.drop_ready); else n_pass++;
  endtask

  task automatic test_abort_clear();
    int kind, k, seen, pulses;
    do_reset();
    model_drop(2, 1'b0, 2'b00, kind, k); do_drop(2, 1'b0, 2'b00);
    handshake(2);
    seen = 0;
    for (int n = 0; n < 10 && seen == 0; n++) begin
      @(negedge clk);
      if (bus.check_en) seen = 1;
    end
    n_checks++; if (seen !== 1) $display("FAIL clear_reach_check got %0d want 1", seen); else n_pass++;
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
    model_reset();
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.drop_done || bus.drop_err || bus.check_en) pulses++;
    end
    n_checks++; if (pulses !== 0) $display("FAIL clear_no_pulse got %0d want 0", pulses); else n_pass++;
    n_checks++; if (!same_board(board, mboard) || move_count !== 6'd0 || current_player !== 2'b01)
      $display("FAIL clear_state count %0d want 0 player %b want 01", move_count, current_player); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_drop();
    test_full_column();
    test_bad_column();
    test_win();
    test_draw();
    test_random();
    test_abort_rst();
    test_abort_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/piece_dropper.md
Name: piece_dropper

Overview:
- Owns the Connect-4 board register array. Accepts column-drop requests from the input/controller side and applies gravity by scanning the column bottom-up. Writes the current player's piece, then pulses check_en to the win checker one cycle later.
- Latches the checker's one-cycle win result, tracks turn, move count, draw and game-over.
- Sits between player input FSM and win checker; board output drives both the checker and the VGA renderer.

Parameters:
- ROWS, 6, board rows; row 0 top, row ROWS-1 bottom
- COLS, 7, board columns; col 0 left
- FIRST_PLAYER, 2'b01, player id owning first move after reset/clear (other id is 2'b10)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous new-game; same effect as rst, highest priority after rst
- drop_valid  in  1  drop request
- drop_col  in  3  requested column
- drop_ready  out  1  high only in IDLE and game_over=0
- drop_done  out  1  one-cycle pulse: piece placed and checked
- drop_err  out  1  one-cycle pulse: request rejected (bad column or column full)
- placed_row  out  3  row of last placed piece, held until next placement
- board  out  2x[0:ROWS-1][0:COLS-1]  cell values: 00 empty, 01/10 player
- current_player  out  2  player whose move is next
- check_en  out  1  one-cycle pulse to win checker
- win_flag  in  1  checker result, valid the cycle after check_en
- winner_id  in  2  checker winner id, same timing
- game_over  out  1  sticky until rst/clear
- winner  out  2  00 = none/draw, else winning id
- draw  out  1  sticky; board filled with no win
- move_count  out  6  pieces placed, 0..ROWS*COLS

Behaviour:
- Reset/clear values:
  - all board cells 00; current_player=FIRST_PLAYER
  - drop_done=drop_err=check_en=0
  - placed_row=0, move_count=0, game_over=0, winner=00, draw=0
  - state=IDLE
- FSM states: IDLE, SCAN, WRITE, CHECK, DONE, ERR.
- IDLE: handshake when drop_valid && drop_ready in cycle T; latch col.
  - drop_col >= COLS -> ERR.
  - Otherwise -> SCAN with row pointer = ROWS-1.
- SCAN: one cell per cycle.
  - board[ptr][col]==00 -> WRITE.
  - Else if ptr==0 -> ERR (column full).
  - Else ptr-- and stay in SCAN.
- WRITE: board[ptr][col] <= current_player; placed_row <= ptr; move_count++; current_player toggles 01<->10. -> CHECK.
- CHECK: check_en=1 for exactly this cycle; board already updated. -> DONE.
- DONE: drop_done=1. Sample win_flag/winner_id.
  - win_flag=1: game_over<=1, winner<=winner_id.
  - Else if move_count==ROWS*COLS: draw<=1, game_over<=1, winner<=00.
  - -> IDLE.
- ERR: drop_err=1 for one cycle; board, player and move_count unchanged. -> IDLE.
- Latency, with k = occupied cells in the column (0..ROWS-1), handshake at cycle T:
  - SCAN occupies T+1..T+1+k; WRITE at T+2+k.
  - New board visible from T+3+k; check_en high at T+3+k; drop_done high at T+4+k.
  - Full column: drop_err at T+ROWS+1. Invalid column: drop_err at T+1.
- drop_valid outside IDLE, or while game_over=1, is ignored; no error pulse.
- drop_done and drop_err are never high together; check_en is high only in CHECK.
- Any ID other than 01/10 is never written.
- rst or clear asserted in any state: abort immediately. No partial write; no done/err pulse.
- win_flag outside DONE is ignored.

Test Plan:
- Reset, drop col 3 at T -> board[5][3]=01 visible at T+3, check_en at T+3, drop_done at T+4, placed_row=5, current_player=10, move_count=1.
- Six drops into col 0, then a seventh -> drop_err at T+7; board, move_count=6 and current_player unchanged; drop_done stays 0.
- drop_col=7 -> drop_err at T+1, no check_en, all state unchanged.
- Model checker drives win_flag=1, winner_id=01 only in the cycle after check_en -> game_over=1, winner=01. A following drop_valid sees drop_ready=0 and the board is unchanged.
- Fill all 42 cells with win_flag held 0 -> the 42nd drop_done sets draw=1, game_over=1, winner=00, move_count=42.
- Assert rst asynchronously mid-SCAN (and separately clear in CHECK) -> all outputs at reset values the next cycle, no drop_done/drop_err pulse, current_player=01.
